// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared state encoding and constants for the UART transmit frame
package uart_tx_pkg;

  localparam int   DEFAULT_DATA_WIDTH = 8;
  localparam logic TX_IDLE            = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - LSB-first shift register and bit counter for the UART data bits
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ser_bit,
  output logic                  ser_done
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= data_in;
      cnt   <= '0;
    end else if (shift_en) begin
      shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
      cnt   <= cnt + CW'(1);
    end
  end

  // ser_bit is the bit the line will carry after this edge, so it looks one ahead while shifting.
  assign ser_bit  = shift_en ? shreg[1] : shreg[0];
  assign ser_done = (cnt == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmit frame sequencer: start, data LSB-first, optional parity, stop
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  par_bit,
  output logic                  TX_OUT,
  output logic                  Busy
);

  state_t state;
  logic   par_q;
  logic   par_en_q;
  logic   load;
  logic   shift_en;
  logic   ser_bit;
  logic   ser_done;

  assign load     = (state == S_IDLE) && Data_Valid;
  assign shift_en = (state == S_DATA) && !ser_done;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (load),
    .shift_en (shift_en),
    .data_in  (P_DATA),
    .ser_bit  (ser_bit),
    .ser_done (ser_done)
  );

  // Outputs are registered with the state so TX_OUT/Busy always describe the current state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      TX_OUT   <= TX_IDLE;
      Busy     <= 1'b0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Data_Valid) begin
            state    <= S_START;
            TX_OUT   <= 1'b0;
            Busy     <= 1'b1;
            par_en_q <= PAR_EN;
          end
        end
        S_START: begin
          // First cycle in which the upstream registered parity matches the accepted byte.
          par_q  <= par_bit;
          TX_OUT <= ser_bit;
          state  <= S_DATA;
        end
        S_DATA: begin
          if (!ser_done) begin
            TX_OUT <= ser_bit;
          end else if (par_en_q) begin
            TX_OUT <= par_q;
            state  <= S_PARITY;
          end else begin
            TX_OUT <= TX_IDLE;
            state  <= S_STOP;
          end
        end
        S_PARITY: begin
          TX_OUT <= TX_IDLE;
          state  <= S_STOP;
        end
        S_STOP: begin
          TX_OUT <= TX_IDLE;
          Busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          TX_OUT <= TX_IDLE;
          Busy   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed table-driven bench for uart_tx_frame
module tb_uart_tx_frame;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       par_bit;
  logic       TX_OUT;
  logic       Busy;

  int errors = 0;
  int checks = 0;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .par_bit    (par_bit),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  // exp lists the line level for cycles 0..10 after the accept edge, left to right.
  typedef struct {
    logic [7:0]  data;
    logic        par_en;
    logic        par;
    int          len;
    logic [10:0] exp;
    int          pulse_at;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int cyc, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(negedge CLK);
    P_DATA     = v.data;
    PAR_EN     = v.par_en;
    par_bit    = ~v.par;
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    Data_Valid = 1'b0;
    par_bit    = v.par;
    P_DATA     = ~v.data;
    PAR_EN     = ~v.par_en;
    for (int i = 0; i < 11; i++) begin
      @(negedge CLK);
      chk({nm, "_tx"}, i, TX_OUT, v.exp[10-i]);
      chk({nm, "_busy"}, i, Busy, (i < v.len));
      if (i == 0) begin
        @(posedge CLK);
        #1;
        par_bit = ~v.par;
      end else if (i == v.pulse_at) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'hFF;
        par_bit    = 1'b1;
        @(posedge CLK);
        #1;
        Data_Valid = 1'b0;
      end
    end
  endtask

  initial begin
    logic [20:0] b2b;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 10, 11'b01010010111, -1};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 11, 11'b01010010101, -1};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 11, 11'b01010010111, -1};
    vecs[3] = '{8'h3C, 1'b1, 1'b0, 11, 11'b00011110001, 4};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 11, 11'b01000000011, -1};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 10, 11'b01111111111, 9};
    vecs[6] = '{8'h00, 1'b1, 1'b0, 11, 11'b00000000001, -1};

    RST        = 1'b0;
    Data_Valid = 1'b0;
    P_DATA     = 8'h00;
    PAR_EN     = 1'b0;
    par_bit    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rst_tx", i, TX_OUT, 1'b1);
      chk("rst_busy", i, Busy, 1'b0);
    end
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("idle_tx", i, TX_OUT, 1'b1);
      chk("idle_busy", i, Busy, 1'b0);
    end

    for (int v = 0; v < 7; v++) run_frame(vecs[v], v);

    // Reset during data bit 4 of 0x55 aborts the frame without waiting for a clock edge.
    @(negedge CLK);
    P_DATA     = 8'h55;
    PAR_EN     = 1'b0;
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    Data_Valid = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge CLK);
    chk("abort_pre_tx", 5, TX_OUT, 1'b1);
    chk("abort_pre_busy", 5, Busy, 1'b1);
    #2;
    RST = 1'b0;
    #1;
    chk("abort_async_tx", 5, TX_OUT, 1'b1);
    chk("abort_async_busy", 5, Busy, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      chk("post_abort_tx", i, TX_OUT, 1'b1);
      chk("post_abort_busy", i, Busy, 1'b0);
    end

    // Data_Valid held high: 0x01 then 0x80, one idle cycle between frames.
    b2b = 21'b010000000110000000011;
    @(negedge CLK);
    P_DATA     = 8'h01;
    PAR_EN     = 1'b0;
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    P_DATA = 8'h80;
    for (int i = 0; i < 21; i++) begin
      @(negedge CLK);
      chk("b2b_tx", i, TX_OUT, b2b[20-i]);
      chk("b2b_busy", i, Busy, (i != 10));
      if (i == 15) Data_Valid = 1'b0;
    end
    @(negedge CLK);
    chk("b2b_end_tx", 21, TX_OUT, 1'b1);
    chk("b2b_end_busy", 21, Busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmit frame sequencer plus serializer. It sits directly downstream of the parity calculator.
- It accepts a parallel byte with Data_Valid and captures the registered parity bit the calculator produces one cycle later.
- It drives the serial line with: start bit, DATA_WIDTH data bits LSB-first, optional parity bit, stop bit.
- One bit is sent per CLK cycle; CLK is the baud-rate clock.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame. Must match the parity calculator width.

Ports:
- CLK  in  1  baud-rate clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- P_DATA  in  DATA_WIDTH  parallel byte to transmit.
- Data_Valid  in  1  request to send P_DATA. Also drives the parity calculator's Data_valid.
- PAR_EN  in  1  1 = insert a parity bit between the data bits and the stop bit.
- par_bit  in  1  registered parity from the parity calculator. Valid the cycle after Data_Valid.
- TX_OUT  out  1  serial line output (registered). Idle/mark level is 1.
- Busy  out  1  high while a frame is in progress. Data_Valid is ignored while Busy=1.

Behaviour:
- Reset: single clock CLK; reset RST is asynchronous and active-low.
  - While RST=0: state=IDLE, TX_OUT=1, Busy=0, shift register=0, bit counter=0, latched parity=0, latched PAR_EN=0.
  - Reset asserted mid-frame aborts the frame immediately: TX_OUT=1, Busy=0. Nothing resumes after reset release.
- States: IDLE, START, DATA, PARITY, STOP. TX_OUT and Busy are registered and reflect the current state.
- IDLE:
  - TX_OUT=1, Busy=0.
  - If Data_Valid=1 at rising edge k: load P_DATA into the shift register, latch PAR_EN, go to START.
  - Data_Valid=0: stay in IDLE.
- START (cycle k+1):
  - TX_OUT=0, Busy=1.
  - At the end of this cycle, capture par_bit into the internal parity register. This is the first cycle in which par_bit reflects the accepted byte.
  - Later par_bit changes, e.g. upstream pulsing Data_Valid while Busy, must not affect the frame.
  - Clear the bit counter; go to DATA.
- DATA (cycles k+2 .. k+1+DATA_WIDTH):
  - TX_OUT = shift register bit 0; shift right each cycle; bit counter increments.
  - After the bit with counter = DATA_WIDTH-1: go to PARITY if latched PAR_EN=1, else go to STOP.
- PARITY (one cycle): TX_OUT = latched parity; go to STOP.
- STOP (one cycle):
  - TX_OUT=1, Busy=1.
  - Go to IDLE. Data_Valid in this cycle is ignored.
- Frame length from the cycle after the accept edge: DATA_WIDTH+2 cycles (10 for 8-bit) without parity, DATA_WIDTH+3 (11) with parity.
- Minimum of one IDLE cycle between frames.
- Data_Valid held high continuously: one frame per DATA_WIDTH+3 (or +4) cycles. Each frame re-samples P_DATA at its accept edge.
- PAR_EN and P_DATA changing mid-frame have no effect.
- Bit counter width is clog2(DATA_WIDTH). Its wrap at DATA_WIDTH-1 is the DATA exit condition.

Decomposition:
- Shared package uart_tx_pkg:
  - state encoding localparams (IDLE, START, DATA, PARITY, STOP; 3 bits, binary);
  - default DATA_WIDTH;
  - TX idle level constant (1'b1).
- One sub-module is natural: uart_tx_serializer.
  - Holds the shift register and bit counter.
  - Ports: load, shift_en, data_in, ser_bit, ser_done.
- The top level holds the FSM, the parity/PAR_EN latches, and the registered TX_OUT mux.

Test Plan:
1. Reset held, then released with Data_Valid=0 -> TX_OUT=1, Busy=0 indefinitely.
2. P_DATA=0xA5, PAR_EN=0, one-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first, stop). Busy high for exactly 10 cycles.
3. P_DATA=0xA5, PAR_EN=1, par_bit from the calculator with PAR_TYP=0 (even, =0) -> 0,1,0,1,0,0,1,0,1,0,1; Busy 11 cycles. Repeat with PAR_TYP=1 -> parity bit slot = 1.
4. Start 0x3C with parity. Pulse Data_Valid with P_DATA=0xFF in DATA-bit 3 (corrupting par_bit) -> frame still shows 0x3C bits and parity 0; the pulse is not accepted.
5. Assert RST during DATA bit 4 of 0x55 -> TX_OUT=1, Busy=0 asynchronously. After release the line stays idle until a new Data_Valid.
6. Data_Valid held high, P_DATA 0x01 then 0x80, PAR_EN=0 -> two frames separated by exactly one idle cycle of TX_OUT=1; the second frame carries 0x80.
